// File: rtl/ram_bus.sv
// ram_bus: parametrised single-port RAM with req/gnt handshake and registered response.
// Define RAM_BUS_CLEAR_EN to zero every word after reset before accepting requests.
module ram_bus #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    output logic                gnt,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH * NB);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       off;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              acc;
    logic              wr_en;

    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Base is span-aligned, so a wrapped offset below base is always >= SPAN.
    assign off      = addr - BASE_ADDR;
    assign in_range = {1'b0, off} < SPAN;
    assign idx      = off[OFF_W +: IDX_W];
    assign acc      = req && gnt;
    assign wr_en    = acc && we && in_range && rst;

`ifdef RAM_BUS_CLEAR_EN
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             clr_en;

    assign gnt    = (state_q == IDLE);
    assign clr_en = (state_q == CLEAR) && rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
`else
    assign gnt = 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
`endif

    always_comb begin
        rvalid_d = acc;
        err_d    = acc && !in_range;
        rdata_d  = rdata_q;
        if (acc && !we) begin
            rdata_d = in_range ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule
